// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file slice.
// Holds the default geometry and the PC-slot predicate.
package regfile_pkg;

  localparam int NREGS_DEF = 16;
  localparam int PC_IDX    = NREGS_DEF - 1;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  function automatic logic is_pc(input reg_addr_t addr);
    return addr == reg_addr_t'(PC_IDX);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: busy flops, set/clear priority, iss_err.
// Ports: ra/we*/wa*/iss_* in; busy_vec, rbusy (clear-qualified), iss_err out.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int NREAD = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREAD*AW-1:0] ra,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_wa,
  output logic [NREGS-1:0] busy_vec,
  output logic [NREAD-1:0] rbusy,
  output logic             iss_err
);

  localparam logic [AW-1:0] PCA = AW'(NREGS - 1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             wr0_v, wr1_v, iss_v;

  assign wr0_v = we0 && (wa0 < PCA);
  assign wr1_v = we1 && (wa1 < PCA);
  assign iss_v = iss_en && (iss_wa < PCA);

  // Issue beats a same-cycle clear so the new producer stays tracked.
  always_comb begin
    busy_d = '0;
    err_d  = 1'b0;
    for (int n = 0; n < NREGS - 1; n++) begin
      logic clr;
      logic set;
      clr = (wr0_v && wa0 == AW'(n)) ||
            (wr1_v && wa1 == AW'(n));
      set = iss_v && iss_wa == AW'(n);
      busy_d[n] = set | (busy_q[n] & ~clr);
      if (set && busy_q[n]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      for (int n = 0; n < NREGS - 1; n++) begin
        if (a == AW'(n)) rbusy[i] = busy_q[n];
      end
      if ((wr0_v && wa0 == a) || (wr1_v && wa1 == a))
        rbusy[i] = 1'b0;
    end
  end

  assign busy_vec = busy_q;
  assign iss_err  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-first bypass, PC slot and scoreboard.
// Ports: ra/rd/rbusy read side, we*/wa*/wd* writes, iss_* issue, busy_vec.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int NREAD = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic [WIDTH-1:0]       r15,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [WIDTH-1:0]       wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [WIDTH-1:0]       wd1,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_wa,
  output logic                   iss_err,
  output logic [NREGS-1:0]       busy_vec
);

  localparam logic [AW-1:0] PCA = AW'(NREGS - 1);

  logic [WIDTH-1:0] rf_q [NREGS-1];
  logic             wr0_v, wr1_v;

  assign wr0_v = we0 && (wa0 < PCA);
  assign wr1_v = we1 && (wa1 < PCA);

  // Port 1 is applied last so a load wins a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NREGS - 1; n++) rf_q[n] <= '0;
    end else begin
      for (int n = 0; n < NREGS - 1; n++) begin
        if (wr0_v && wa0 == AW'(n)) rf_q[n] <= wd0;
        if (wr1_v && wa1 == AW'(n)) rf_q[n] <= wd1;
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] v;
      a = ra[i*AW +: AW];
      v = '0;
      for (int n = 0; n < NREGS - 1; n++) begin
        if (a == AW'(n)) v = rf_q[n];
      end
      if (wr0_v && wa0 == a) v = wd0;
      if (wr1_v && wa1 == a) v = wd1;
      if (a == PCA) v = r15;
      rd[i*WIDTH +: WIDTH] = v;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra       (ra),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .iss_en   (iss_en),
    .iss_wa   (iss_wa),
    .busy_vec (busy_vec),
    .rbusy    (rbusy),
    .iss_err  (iss_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
// One task per scenario; each task does its own inline checks.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] ra = '0;
  logic [95:0] rd;
  logic [2:0]  rbusy;
  logic [31:0] r15 = '0;
  logic        we0 = 1'b0;
  logic [3:0]  wa0 = '0;
  logic [31:0] wd0 = '0;
  logic        we1 = 1'b0;
  logic [3:0]  wa1 = '0;
  logic [31:0] wd1 = '0;
  logic        iss_en = 1'b0;
  logic [3:0]  iss_wa = '0;
  logic        iss_err;
  logic [15:0] busy_vec;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .r15      (r15),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .iss_en   (iss_en),
    .iss_wa   (iss_wa),
    .iss_err  (iss_err),
    .busy_vec (busy_vec)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    ra = {4'd3, 4'd2, 4'd1};
    r15 = 32'h0000_0108;
    #1;
    n_run++;
    if (rd !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_rd got %h want 0", rd);
    end
    n_run++;
    if (busy_vec !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_busy got %h want 0", busy_vec);
    end
    n_run++;
    if (iss_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b want 0", iss_err);
    end
    ra = {4'd3, 4'd2, 4'd15};
    #1;
    n_run++;
    if (rd[31:0] !== 32'h0000_0108) begin
      n_fail++;
      $display("FAIL reset_r15 got %h want 00000108", rd[31:0]);
    end
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd4; wd0 = 32'hDEAD_BEEF;
    ra = {4'd0, 4'd0, 4'd4};
    #1;
    n_run++;
    if (rd[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_comb got %h want deadbeef", rd[31:0]);
    end
    step();
    idle();
    #1;
    n_run++;
    if (rd[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_stored got %h want deadbeef", rd[31:0]);
    end
  endtask

  task automatic test_collision();
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
    ra = {4'd0, 4'd5, 4'd4};
    #1;
    n_run++;
    if (rd[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL coll_bypass got %h want 22", rd[63:32]);
    end
    step();
    idle();
    #1;
    n_run++;
    if (rd[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL coll_stored got %h want 22", rd[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_wa = 4'd7;
    ra = {4'd0, 4'd0, 4'd7};
    #1;
    n_run++;
    if (rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_issue_early got %b want 0", rbusy[0]);
    end
    step();
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h0080 || rbusy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set got %h/%b want 0080/1", busy_vec, rbusy[0]);
    end
    we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h77;
    #1;
    n_run++;
    if (rbusy[0] !== 1'b0 || rd[31:0] !== 32'h77) begin
      n_fail++;
      $display("FAIL sb_wr_cycle got %b/%h want 0/77", rbusy[0], rd[31:0]);
    end
    step();
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h0) begin
      n_fail++;
      $display("FAIL sb_clear got %h want 0", busy_vec);
    end
    iss_en = 1'b1; iss_wa = 4'd8;
    we1 = 1'b1; wa1 = 4'd8; wd1 = 32'h88;
    step();
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h0100) begin
      n_fail++;
      $display("FAIL sb_issue_wins got %h want 0100", busy_vec);
    end
    we0 = 1'b1; wa0 = 4'd8; wd0 = 32'h99;
    step();
    idle();
    we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h9;
    step();
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h0) begin
      n_fail++;
      $display("FAIL sb_unscored got %h want 0", busy_vec);
    end
  endtask

  task automatic test_double_issue();
    iss_en = 1'b1; iss_wa = 4'd3;
    step();
    n_run++;
    if (iss_err !== 1'b0 || busy_vec !== 16'h0008) begin
      n_fail++;
      $display("FAIL dbl_first got %b/%h want 0/0008", iss_err, busy_vec);
    end
    step();
    idle();
    #1;
    n_run++;
    if (iss_err !== 1'b1 || busy_vec !== 16'h0008) begin
      n_fail++;
      $display("FAIL dbl_err got %b/%h want 1/0008", iss_err, busy_vec);
    end
    step();
    n_run++;
    if (iss_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_err_pulse got %b want 0", iss_err);
    end
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h3;
    step();
    idle();
    #1;
  endtask

  task automatic test_pc();
    iss_en = 1'b1; iss_wa = 4'd15;
    step();
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h0 || iss_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_issue got %h/%b want 0/0", busy_vec, iss_err);
    end
    r15 = 32'h0000_0200;
    we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h0BAD;
    ra = {4'd14, 4'd0, 4'd15};
    #1;
    n_run++;
    if (rd[31:0] !== 32'h200 || rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_wr_comb got %h/%b want 200/0", rd[31:0], rbusy[0]);
    end
    step();
    idle();
    #1;
    n_run++;
    if (rd[31:0] !== 32'h200 || rd[95:64] !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wr_stored got %h/%h want 200/0", rd[31:0], rd[95:64]);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 4; k < 8; k++) begin
      iss_en = 1'b1; iss_wa = 4'(k);
      step();
    end
    idle();
    #1;
    n_run++;
    if (busy_vec !== 16'h00F0) begin
      n_fail++;
      $display("FAIL mid_setup got %h want 00f0", busy_vec);
    end
    we0 = 1'b1; wa0 = 4'd9; wd0 = 32'hCAFE;
    ra = {4'd9, 4'd5, 4'd4};
    #2;
    reset_n = 1'b0;
    #1;
    n_run++;
    if (busy_vec !== 16'h0 || iss_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got %h/%b want 0/0", busy_vec, iss_err);
    end
    n_run++;
    if (rd !== {32'hCAFE, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_rf got %h want 0000cafe,0,0", rd);
    end
    idle();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_run++;
    if (rd !== 96'h0) begin
      n_fail++;
      $display("FAIL mid_after got %h want 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_double_issue();
    test_pc();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
